// File: rtl/game_defs.sv
// Shared game constants: move directions, controller states, grid bounds.
// Used by the move controller, the renderer and the map ROM.
package game_defs;

  localparam int COORD_W = 10;

  localparam int GRID_X_MIN   = 1;
  localparam int GRID_X_MAX   = 20;
  localparam int GRID_Y_MIN   = 1;
  localparam int GRID_Y_MAX   = 15;
  localparam int GRID_X_START = 10;
  localparam int GRID_Y_START = 15;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } move_state_t;

endpackage

// File: rtl/move_fifo.sv
// Small FIFO of pending move directions.
// A push into a full FIFO is accepted when a pop happens the same cycle.
module move_fifo
  import game_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  dir_t        din,
  input  logic        pop,
  output dir_t        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  dir_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: queues button moves, bounds-checks them,
// asks the map port about walls, then commits or rejects each move.
module player_move_ctrl
  import game_defs::*;
#(
  parameter int X_MIN      = GRID_X_MIN,
  parameter int X_MAX      = GRID_X_MAX,
  parameter int Y_MIN      = GRID_Y_MIN,
  parameter int Y_MAX      = GRID_Y_MAX,
  parameter int X_START    = GRID_X_START,
  parameter int Y_START    = GRID_Y_START,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_move_up,
  input  logic         i_move_down,
  input  logic         i_move_left,
  input  logic         i_move_right,
  output logic         o_map_req,
  output logic [9:0]   o_map_x,
  output logic [9:0]   o_map_y,
  input  logic         i_map_ack,
  input  logic         i_map_wall,
  output logic [9:0]   o_player_x,
  output logic [9:0]   o_player_y,
  output logic         o_moved,
  output logic         o_blocked,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [9:0] XMIN = 10'(X_MIN);
  localparam logic [9:0] XMAX = 10'(X_MAX);
  localparam logic [9:0] YMIN = 10'(Y_MIN);
  localparam logic [9:0] YMAX = 10'(Y_MAX);

  move_state_t state;
  dir_t        req_dir;
  dir_t        head;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        in_bounds;
  logic [9:0]  tgt_x;
  logic [9:0]  tgt_y;

  assign push = i_move_up | i_move_down
              | i_move_left | i_move_right;
  assign pop  = (state == ST_IDLE) && !empty;

  // Same-cycle presses: up beats down beats left beats right.
  always_comb begin
    req_dir = DIR_RIGHT;
    if (i_move_up)        req_dir = DIR_UP;
    else if (i_move_down) req_dir = DIR_DOWN;
    else if (i_move_left) req_dir = DIR_LEFT;
  end

  move_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .push  (push),
    .din   (req_dir),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Bounds are checked on the current position, so no wrap is possible.
  always_comb begin
    in_bounds = 1'b0;
    tgt_x     = o_player_x;
    tgt_y     = o_player_y;
    unique case (head)
      DIR_UP: begin
        in_bounds = o_player_y > YMIN;
        tgt_y     = o_player_y - 10'd1;
      end
      DIR_DOWN: begin
        in_bounds = o_player_y < YMAX;
        tgt_y     = o_player_y + 10'd1;
      end
      DIR_LEFT: begin
        in_bounds = o_player_x > XMIN;
        tgt_x     = o_player_x - 10'd1;
      end
      DIR_RIGHT: begin
        in_bounds = o_player_x < XMAX;
        tgt_x     = o_player_x + 10'd1;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      o_player_x <= 10'(X_START);
      o_player_y <= 10'(Y_START);
      o_map_x    <= '0;
      o_map_y    <= '0;
      o_map_req  <= 1'b0;
      o_moved    <= 1'b0;
      o_blocked  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_moved    <= 1'b0;
      o_blocked  <= 1'b0;
      o_overflow <= push && full && !pop;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            if (in_bounds) begin
              o_map_x   <= tgt_x;
              o_map_y   <= tgt_y;
              o_map_req <= 1'b1;
              state     <= ST_REQ;
            end else begin
              o_blocked <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (i_map_ack) begin
            o_map_req <= 1'b0;
            state     <= ST_IDLE;
            if (i_map_wall) begin
              o_blocked <= 1'b1;
            end else begin
              o_player_x <= o_map_x;
              o_player_y <= o_map_y;
              o_moved    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE) | (count != '0);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus random traffic
// against a queue-based move model compared every cycle.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b0, down = 1'b0;
  logic       left = 1'b0, right = 1'b0;
  logic       ack = 1'b0, wall = 1'b0;
  logic       map_req, moved, blocked, overflow, busy;
  logic [9:0] map_x, map_y, px_o, py_o;

  player_move_ctrl dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_move_up    (up),
    .i_move_down  (down),
    .i_move_left  (left),
    .i_move_right (right),
    .o_map_req    (map_req),
    .o_map_x      (map_x),
    .o_map_y      (map_y),
    .i_map_ack    (ack),
    .i_map_wall   (wall),
    .o_player_x   (px_o),
    .o_player_y   (py_o),
    .o_moved      (moved),
    .o_blocked    (blocked),
    .o_overflow   (overflow),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of directions and an optional pending lookup.
  int q[$];
  int mpx, mpy, mtx, mty, mmx, mmy;
  bit lk, e_moved, e_blocked, e_ovf, mvalid = 0;
  int n0, d, w, nx, ny;
  bit popn;
  int dxs[4] = '{0, 0, -1, 1};
  int dys[4] = '{-1, 1, 0, 0};

  always @(posedge clk) begin
    if (!rst_n) begin
      mpx = 10; mpy = 15; mmx = 0; mmy = 0;
      q.delete(); lk = 0;
      e_moved = 0; e_blocked = 0; e_ovf = 0;
      mvalid = 1;
    end else if (mvalid) begin
      e_moved = 0; e_blocked = 0; e_ovf = 0;
      n0 = q.size();
      popn = !lk && n0 > 0;
      if (lk) begin
        if (ack) begin
          lk = 0;
          if (wall) e_blocked = 1;
          else begin mpx = mtx; mpy = mty; e_moved = 1; end
        end
      end else if (popn) begin
        d = q.pop_front();
        nx = mpx + dxs[d];
        ny = mpy + dys[d];
        if (nx >= 1 && nx <= 20 && ny >= 1 && ny <= 15) begin
          lk = 1; mtx = nx; mty = ny; mmx = nx; mmy = ny;
        end else e_blocked = 1;
      end
      w = up ? 0 : down ? 1 : left ? 2 : right ? 3 : -1;
      if (w >= 0) begin
        if (n0 < 4 || popn) q.push_back(w);
        else e_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("player_x", int'(px_o), mpx);
      chk("player_y", int'(py_o), mpy);
      chk("map_req", int'(map_req), int'(lk));
      chk("map_x", int'(map_x), mmx);
      chk("map_y", int'(map_y), mmy);
      chk("moved", int'(moved), int'(e_moved));
      chk("blocked", int'(blocked), int'(e_blocked));
      chk("overflow", int'(overflow), int'(e_ovf));
      chk("busy", int'(busy), int'(lk || q.size() != 0));
    end
  end

  // Pulse counters and last lookup address, sampled before each edge.
  int c_moved, c_blocked, c_ovf, c_req, last_mx, last_my;
  always @(posedge clk) begin
    if (moved) c_moved++;
    if (blocked) c_blocked++;
    if (overflow) c_ovf++;
    if (map_req) begin
      c_req++; last_mx = int'(map_x); last_my = int'(map_y);
    end
  end

  // Map responder: 0 never acks, 1 acks at once, 2 random, 3 manual.
  int  mode = 0;
  bit  wall_val = 0;
  bit  force_ack = 0;
  always @(negedge clk) begin
    case (mode)
      1: begin ack = map_req; wall = wall_val; end
      2: begin
        ack  = map_req && ($urandom_range(0, 2) == 0);
        wall = 1'($urandom_range(0, 1));
      end
      3: begin ack = force_ack; wall = 1'b0; end
      default: begin ack = 1'b0; wall = 1'b0; end
    endcase
  end

  task automatic clr();
    c_moved = 0; c_blocked = 0; c_ovf = 0; c_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {up, down, left, right} = m;
    @(negedge clk);
    {up, down, left, right} = 4'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit done;

  initial begin
    idle(3);
    rst_n = 1'b1;
    chk("reset_x", int'(px_o), 10);
    chk("reset_y", int'(py_o), 15);
    chk("reset_req", int'(map_req), 0);
    chk("reset_busy", int'(busy), 0);

    // Single RIGHT, immediate ack, no wall.
    mode = 1; wall_val = 0; clr();
    pulse(4'b0001);
    chk("right_n0_x", int'(px_o), 10);
    idle(1);
    chk("right_n1_x", int'(px_o), 10);
    idle(1);
    chk("right_n2_x", int'(px_o), 11);
    idle(3);
    chk("right_moves", c_moved, 1);
    chk("right_y", int'(py_o), 15);

    // DOWN at bottom row, then UP into a wall.
    do_reset(); clr();
    pulse(4'b0100);
    idle(4);
    chk("down_blocked", c_blocked, 1);
    chk("down_no_req", c_req, 0);
    chk("down_y", int'(py_o), 15);
    wall_val = 1;
    pulse(4'b1000);
    idle(5);
    chk("wall_blocked", c_blocked, 2);
    chk("wall_map_x", last_mx, 10);
    chk("wall_map_y", last_my, 14);
    chk("wall_y", int'(py_o), 15);
    chk("wall_moves", c_moved, 0);

    // UP and LEFT together: UP wins.
    wall_val = 0; clr();
    pulse(4'b1010);
    idle(6);
    chk("prio_x", int'(px_o), 10);
    chk("prio_y", int'(py_o), 14);
    chk("prio_moves", c_moved, 1);

    // Stalled map with a burst of LEFTs fills and overflows the FIFO.
    do_reset(); mode = 0; clr();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      left = 1'b1;
    end
    @(negedge clk);
    left = 1'b0;
    idle(3);
    chk("burst_ovf", c_ovf, 2);
    chk("burst_map_x", int'(map_x), 9);
    chk("burst_map_y", int'(map_y), 15);
    chk("burst_busy", int'(busy), 1);
    mode = 1;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("burst_drain_done", int'(done), 1);
    chk("burst_moved_at_idle", int'(moved), 1);
    idle(1);
    chk("burst_x", int'(px_o), 5);
    chk("burst_moves", c_moved, 5);

    // Walk to the left edge, then one more LEFT must be blocked.
    for (int i = 0; i < 4; i++) begin
      pulse(4'b0010);
      idle(4);
    end
    chk("edge_x", int'(px_o), 1);
    clr();
    pulse(4'b0010);
    idle(4);
    chk("edge_blocked", c_blocked, 1);
    chk("edge_x_kept", int'(px_o), 1);

    // Reset mid-lookup with entries queued; a stale ack is ignored.
    do_reset(); mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      left = 1'b1;
    end
    @(negedge clk);
    left = 1'b0;
    chk("pre_rst_req", int'(map_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x", int'(px_o), 10);
    chk("rst_y", int'(py_o), 15);
    chk("rst_req", int'(map_req), 0);
    chk("rst_busy", int'(busy), 0);
    clr();
    mode = 3; force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    idle(3);
    chk("stale_ack_moves", c_moved, 0);
    chk("stale_ack_x", int'(px_o), 10);

    // Random traffic against the model.
    mode = 2;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      up    = ($urandom_range(0, 6) == 0);
      down  = ($urandom_range(0, 6) == 0);
      left  = ($urandom_range(0, 6) == 0);
      right = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    {up, down, left, right} = 4'b0;
    rst_n = 1'b1;
    mode = 1;
    idle(30);
    chk("final_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
